// File: rtl/fsm_mode_controller.sv
// Clock edit-mode sequencer: debounced MODE/UP buttons drive the 3-bit mode.
// Optional idle return to NORMAL is built when MODE_TIMEOUT_EN is defined.
module fsm_mode_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_S       = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       pulse_1s,
   output logic [2:0] state,
   output logic       mode_changed,
   output logic       inc_pulse
);

   typedef enum logic [2:0] {
      NORMAL = 3'b000,
      SS     = 3'b001,
      MI     = 3'b010,
      HH     = 3'b011,
      DD     = 3'b100,
      MO     = 3'b101,
      YY     = 3'b110,
      ILL    = 3'b111
   } mode_e;

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // bit 0 = MODE, bit 1 = UP
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    lvl_q;
   logic [1:0]    lvl_prev_q;
   logic [CW-1:0] cnt_q [2];

   logic  mode_edge;
   logic  up_edge;
   logic  expire;
   mode_e state_q;
   mode_e adv_d;
   logic  mode_changed_q;
   logic  inc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lvl_q      <= '0;
         lvl_prev_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q    <= {btn_up, btn_mode};
         sync2_q    <= sync1_q;
         lvl_prev_q <= lvl_q;
         // Accept the new level on the last of the required stable samples.
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] >= DB_LAST) begin
               lvl_q[i] <= sync2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign mode_edge = lvl_q[0] & ~lvl_prev_q[0];
   assign up_edge   = lvl_q[1] & ~lvl_prev_q[1];

   always_comb begin
      adv_d = NORMAL;
      unique case (state_q)
         NORMAL:  adv_d = SS;
         SS:      adv_d = MI;
         MI:      adv_d = HH;
         HH:      adv_d = DD;
         DD:      adv_d = MO;
         MO:      adv_d = YY;
         default: adv_d = NORMAL;
      endcase
   end

`ifdef MODE_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_S + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

   logic [TW-1:0] idle_q;

   assign expire = pulse_1s && (idle_q == TO_LAST) && (state_q != NORMAL);

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
      end else if (state_q == NORMAL || state_q == ILL ||
                   mode_edge || up_edge || expire) begin
         idle_q <= '0;
      end else if (pulse_1s) begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_S;
   logic          unused_pulse;

   assign expire       = 1'b0;
   assign unused_pulse = pulse_1s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= NORMAL;
         mode_changed_q <= 1'b0;
         inc_q          <= 1'b0;
      end else begin
         mode_changed_q <= 1'b0;
         inc_q          <= 1'b0;
         if (state_q == ILL) begin
            state_q        <= NORMAL;
            mode_changed_q <= 1'b1;
         end else if (mode_edge) begin
            state_q        <= adv_d;
            mode_changed_q <= 1'b1;
         end else if (up_edge && state_q != NORMAL) begin
            inc_q <= 1'b1;
         end else if (expire) begin
            state_q        <= NORMAL;
            mode_changed_q <= 1'b1;
         end
      end
   end

   assign state        = state_q;
   assign mode_changed = mode_changed_q;
   assign inc_pulse    = inc_q;

endmodule

// File: tb/tb_fsm_mode_controller.sv
// Bench for fsm_mode_controller: directed scenarios plus random button traffic
// checked cycle by cycle against a history-based behavioural model.
module tb_fsm_mode_controller;

   localparam int DEB = 4;
   localparam int TO  = 3;
`ifdef MODE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_up;
   logic       pulse_1s;
   logic [2:0] state;
   logic       mode_changed;
   logic       inc_pulse;

   int vectors  = 0;
   int miscmp   = 0;

   always #5 clk = ~clk;

   fsm_mode_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_S      (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_mode    (btn_mode),
      .btn_up      (btn_up),
      .pulse_1s    (pulse_1s),
      .state       (state),
      .mode_changed(mode_changed),
      .inc_pulse   (inc_pulse)
   );

   // Model: raw-sample history; a level flips once the DEB samples that are
   // two clocks old all disagree with it. Modes advance modulo 7.
   logic [15:0] hm, hu;
   bit          lm, lu, pm, pu, nm, nu;
   int          m_state, m_idle;
   bit          m_mc, m_inc;
   logic [4:0]  exp_v, dut_v;

   assign dut_v = {state, mode_changed, inc_pulse};
   assign exp_v = {m_state[2:0], m_mc, m_inc};

   function automatic bit settle(input logic [15:0] h, input bit l);
      for (int i = 2; i < DEB + 2; i++) if (h[i] == l) return l;
      return ~l;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         hm = '0; hu = '0; lm = 0; lu = 0; pm = 0; pu = 0;
         m_state = 0; m_idle = 0; m_mc = 0; m_inc = 0;
      end else begin
         m_mc = 0;
         m_inc = 0;
         if (pm) begin
            m_state = (m_state + 1) % 7;
            m_mc = 1;
            m_idle = 0;
         end else if (pu && m_state != 0) begin
            m_inc = 1;
            m_idle = 0;
         end else if (TO_EN && m_state != 0 && pulse_1s) begin
            m_idle++;
            if (m_idle == TO) begin
               m_state = 0;
               m_mc = 1;
               m_idle = 0;
            end
         end
         if (m_state == 0) m_idle = 0;
         hm = {hm[14:0], btn_mode};
         hu = {hu[14:0], btn_up};
         nm = settle(hm, lm);
         nu = settle(hu, lu);
         pm = nm && !lm;
         pu = nu && !lu;
         lm = nm;
         lu = nu;
      end
   end

   task automatic cyc(input bit m, input bit u, input bit p);
      btn_mode = m;
      btn_up   = u;
      pulse_1s = p;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic press(input int n);
      repeat (n) begin
         repeat (10) cyc(1, 0, 0);
         repeat (10) cyc(0, 0, 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      vectors++;
      if (dut_v !== 5'b0) begin
         miscmp++;
         $display("FAIL reset: got %b want 00000", dut_v);
      end
      rst = 1'b0;
      repeat (10) cyc(0, 0, 0);
   endtask

   task automatic test_mode_cycle();
      logic [2:0] prev, want;
      int hit, pulses;
      for (int s = 1; s <= 7; s++) begin
         hit = 0;
         pulses = 0;
         prev = state;
         for (int n = 1; n <= 10; n++) begin
            cyc(1, 0, 0);
            vectors++;
            if (dut_v !== exp_v) begin
               miscmp++;
               $display("FAIL mode_cycle s=%0d n=%0d: got %b want %b",
                        s, n, dut_v, exp_v);
            end
            if (hit == 0 && state !== prev) hit = n;
            if (mode_changed) pulses++;
         end
         want = 3'(s % 7);
         vectors++;
         if (hit != 7) begin
            miscmp++;
            $display("FAIL mode_latency s=%0d: got %0d want 7", s, hit);
         end
         vectors++;
         if (state !== want) begin
            miscmp++;
            $display("FAIL mode_seq s=%0d: got %b want %b", s, state, want);
         end
         vectors++;
         if (pulses != 1) begin
            miscmp++;
            $display("FAIL mode_changed_cnt s=%0d: got %0d want 1", s, pulses);
         end
         repeat (10) cyc(0, 0, 0);
      end
   endtask

   task automatic test_glitch();
      int moved, incs;
      moved = 0;
      incs = 0;
      for (int c = 0; c < 63; c++) begin
         cyc(c < 3, c >= 13 && c < 53, 0);
         vectors++;
         if (dut_v !== exp_v) begin
            miscmp++;
            $display("FAIL glitch c=%0d: got %b want %b", c, dut_v, exp_v);
         end
         if (state !== 3'b000) moved++;
         if (inc_pulse) incs++;
      end
      vectors++;
      if (moved != 0 || incs != 0) begin
         miscmp++;
         $display("FAIL glitch_quiet: got moved=%0d inc=%0d want 0/0",
                  moved, incs);
      end
   endtask

   task automatic test_up_inc();
      int incs, hold;
      press(1);
      incs = 0;
      for (int k = 0; k < 2; k++) begin
         hold = $urandom_range(8, 14);
         for (int c = 0; c < hold + 10; c++) begin
            cyc(0, c < hold, 0);
            vectors++;
            if (dut_v !== exp_v) begin
               miscmp++;
               $display("FAIL up_inc k=%0d c=%0d: got %b want %b",
                        k, c, dut_v, exp_v);
            end
            if (inc_pulse) incs++;
         end
      end
      vectors++;
      if (incs != 2 || state !== 3'b001) begin
         miscmp++;
         $display("FAIL up_two: got inc=%0d st=%b want 2 001", incs, state);
      end
      incs = 0;
      for (int c = 0; c < 110; c++) begin
         cyc(0, c < 100, 0);
         if (inc_pulse) incs++;
      end
      vectors++;
      if (incs != 1) begin
         miscmp++;
         $display("FAIL up_held: got inc=%0d want 1", incs);
      end
   endtask

   task automatic test_simul();
      int incs;
      press(2);
      incs = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(c < 10, c < 10, 0);
         vectors++;
         if (dut_v !== exp_v) begin
            miscmp++;
            $display("FAIL simul c=%0d: got %b want %b", c, dut_v, exp_v);
         end
         if (inc_pulse) incs++;
      end
      vectors++;
      if (state !== 3'b100 || incs != 0) begin
         miscmp++;
         $display("FAIL simul_win: got st=%b inc=%0d want 100 0", state, incs);
      end
   endtask

`ifdef MODE_TIMEOUT_EN
   task automatic test_timeout();
      logic [2:0] want;
      press(5);
      for (int t = 1; t <= 3; t++) begin
         repeat (4) cyc(0, 0, 0);
         cyc(0, 0, 1);
         want = (t == 3) ? 3'b000 : 3'b010;
         vectors++;
         if (state !== want || mode_changed !== (t == 3)) begin
            miscmp++;
            $display("FAIL timeout t=%0d: got %b/%b want %b/%b",
                     t, state, mode_changed, want, t == 3);
         end
      end
      press(2);
      for (int t = 1; t <= 5; t++) begin
         if (t == 3) begin
            for (int c = 0; c < 20; c++) begin
               cyc(0, c < 10, 0);
               vectors++;
               if (dut_v !== exp_v) begin
                  miscmp++;
                  $display("FAIL timeout_up c=%0d: got %b want %b",
                           c, dut_v, exp_v);
               end
            end
         end
         repeat (4) cyc(0, 0, 0);
         cyc(0, 0, 1);
         want = (t == 5) ? 3'b000 : 3'b010;
         vectors++;
         if (state !== want || mode_changed !== (t == 5)) begin
            miscmp++;
            $display("FAIL timeout_restart t=%0d: got %b/%b want %b/%b",
                     t, state, mode_changed, want, t == 5);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      int hit;
      rst = 1'b1;
      cyc(0, 0, 0);
      rst = 1'b0;
      press(4);
      vectors++;
      if (state !== 3'b100) begin
         miscmp++;
         $display("FAIL reset_mid_pre: got %b want 100", state);
      end
      repeat (4) cyc(1, 0, 0);
      rst = 1'b1;
      cyc(1, 0, 0);
      rst = 1'b0;
      vectors++;
      if (dut_v !== 5'b0) begin
         miscmp++;
         $display("FAIL reset_mid: got %b want 00000", dut_v);
      end
      hit = 0;
      for (int n = 1; n <= 12; n++) begin
         cyc(1, 0, 0);
         if (hit == 0 && state !== 3'b000) hit = n;
      end
      vectors++;
      if (hit != 7 || state !== 3'b001) begin
         miscmp++;
         $display("FAIL reset_redebounce: got n=%0d st=%b want 7 001",
                  hit, state);
      end
      repeat (10) cyc(0, 0, 0);
   endtask

   task automatic test_random();
      bit m, u;
      int len;
      for (int r = 0; r < 150; r++) begin
         m = 1'($urandom_range(0, 1));
         u = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 14);
         for (int c = 0; c < len; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc(m, u, $urandom_range(0, 7) == 0);
            rst = 1'b0;
            vectors++;
            if (dut_v !== exp_v) begin
               miscmp++;
               $display("FAIL random r=%0d c=%0d: got %b want %b",
                        r, c, dut_v, exp_v);
            end
            vectors++;
            if (mode_changed && inc_pulse) begin
               miscmp++;
               $display("FAIL random_excl r=%0d: got mc=1 inc=1 want not both",
                        r);
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      pulse_1s = 1'b0;
      @(negedge clk);
      test_reset();
      test_mode_cycle();
      test_glitch();
      test_up_inc();
      test_simul();
`ifdef MODE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end

endmodule
